// File: rtl/game_pkg.sv
// Shared game constants and the motion state type used by the sprite movers.
//   H_ACTIVE/V_ACTIVE : visible screen size in pixels
//   SPRITE_SIZE       : on-screen sprite edge (8 px art, scale 3)
//   POS_W/CALC_W      : position width and the one-bit-wider arithmetic width
//   CNT_W             : frame counter / step period width (periods 1..63)
package game_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned SPRITE_SIZE = 24;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned CALC_W = 11;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } motion_state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// One-clk frame tick on the rising edge of a registered line comparator.
//   clk, reset : clock, async active-high reset
//   v_counter  : VGA vertical counter
//   tick_c     : single-cycle pulse once per frame (combinational from flops)
module frame_tick_gen
  import game_pkg::*;
#(
  parameter int unsigned TICK_LINE = V_ACTIVE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] v_counter,
  output logic             tick_c
);

  logic on_line_q;
  logic armed_q;

  // The comparator resets "on the line" and the arm flag resets clear, so an
  // edge is only recognised after the line has been seen inactive once. This
  // keeps v_counter sitting on the tick line across reset from firing a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_line_q <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      on_line_q <= (v_counter == POS_W'(TICK_LINE));
      armed_q   <= ~on_line_q;
    end
  end

  assign tick_c = on_line_q & armed_q;

endmodule

// File: rtl/enemy_motion_ctrl.sv
// Invader-style enemy marcher: steps horizontally once per period of frames,
// drops and reverses at a side edge, stops at the bottom limit.
//   clk, reset      : clock, async active-high reset
//   h_counter       : VGA horizontal counter (not used by the logic)
//   v_counter       : VGA vertical counter, source of the frame tick
//   enable          : game running; low pauses motion
//   alive           : enemy alive; low freezes the frame count
//   speed_up        : one-clk pulse, shortens the step period
//   posX, posY      : enemy sprite position
//   dir             : 0 moving right, 1 moving left
//   step_pulse      : one-clk pulse after each executed step or drop
//   reached_bottom  : sticky, set when posY reaches Y_LIMIT
module enemy_motion_ctrl
  import game_pkg::*;
#(
  parameter int unsigned X_INIT          = 40,
  parameter int unsigned Y_INIT          = 40,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = H_ACTIVE - SPRITE_SIZE,
  parameter int unsigned STEP_X          = 4,
  parameter int unsigned STEP_Y          = 24,
  parameter int unsigned Y_LIMIT         = V_ACTIVE,
  parameter int unsigned FRAMES_PER_STEP = 30,
  parameter int unsigned MIN_PERIOD      = 4,
  parameter int unsigned V_TICK_LINE     = V_ACTIVE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] h_counter,
  input  logic [POS_W-1:0] v_counter,
  input  logic             enable,
  input  logic             alive,
  input  logic             speed_up,
  output logic [POS_W-1:0] posX,
  output logic [POS_W-1:0] posY,
  output logic             dir,
  output logic             step_pulse,
  output logic             reached_bottom
);

  motion_state_e    state_q, state_d;
  motion_state_e    resume_q, resume_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d;
  logic [POS_W-1:0] pos_y_q, pos_y_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             step_pulse_q, step_pulse_d;
  logic             bottom_q, bottom_d;

  logic              frame_tick_c;
  logic [CNT_W:0]    cnt_inc;
  logic              terminal;
  logic [CNT_W-1:0]  period_dec;
  logic [CALC_W-1:0] x_plus;
  logic [CALC_W-1:0] y_plus;
  logic              unused_h;

  assign unused_h = ^h_counter;

  frame_tick_gen #(
    .TICK_LINE (V_TICK_LINE)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .v_counter (v_counter),
    .tick_c    (frame_tick_c)
  );

  // Terminal count uses ">=" so a period shortened below the running count
  // forces a step on the next tick instead of wrapping the counter.
  assign cnt_inc    = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
  assign terminal   = (cnt_inc >= (CNT_W+1)'(period_q));
  assign period_dec = (period_q > CNT_W'(MIN_PERIOD)) ? (period_q - CNT_W'(1))
                                                      : CNT_W'(MIN_PERIOD);

  // Edge tests are done one bit wider than the position so nothing wraps.
  assign x_plus = CALC_W'(pos_x_q) + CALC_W'(STEP_X);
  assign y_plus = CALC_W'(pos_y_q) + CALC_W'(STEP_Y);

  // Next-state, datapath and output decode.
  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    step_pulse_d = 1'b0;
    bottom_d     = bottom_q;

    // Period update sees the old period in the compare below, so a speed-up
    // landing on a terminal tick takes effect from the following count.
    if (speed_up && (state_q != HALT)) begin
      period_d = period_dec;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = resume_q;
        end
      end

      MOVE, DROP: begin
        if (!enable) begin
          state_d  = IDLE;
          resume_d = state_q;
        end else if (frame_tick_c && alive) begin
          if (terminal) begin
            cnt_d        = '0;
            step_pulse_d = 1'b1;
            if (state_q == DROP) begin
              if (y_plus >= CALC_W'(Y_LIMIT)) begin
                pos_y_d  = POS_W'(Y_LIMIT);
                bottom_d = 1'b1;
                state_d  = HALT;
              end else begin
                pos_y_d = POS_W'(y_plus);
                dir_d   = ~dir_q;
                state_d = MOVE;
              end
            end else if (!dir_q) begin
              if (x_plus > CALC_W'(X_MAX)) begin
                state_d = DROP;
              end else begin
                pos_x_d = POS_W'(x_plus);
              end
            end else begin
              if (CALC_W'(pos_x_q) < (CALC_W'(X_MIN) + CALC_W'(STEP_X))) begin
                state_d = DROP;
              end else begin
                pos_x_d = pos_x_q - POS_W'(STEP_X);
              end
            end
          end else begin
            cnt_d = CNT_W'(cnt_inc);
          end
        end
      end

      HALT: begin
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      resume_q     <= MOVE;
      pos_x_q      <= POS_W'(X_INIT);
      pos_y_q      <= POS_W'(Y_INIT);
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      period_q     <= CNT_W'(FRAMES_PER_STEP);
      step_pulse_q <= 1'b0;
      bottom_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      step_pulse_q <= step_pulse_d;
      bottom_q     <= bottom_d;
    end
  end

  assign posX           = pos_x_q;
  assign posY           = pos_y_q;
  assign dir            = dir_q;
  assign step_pulse     = step_pulse_q;
  assign reached_bottom = bottom_q;

endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// Randomized frame-level bench for enemy_motion_ctrl against a reference
// model of the marching rules.
module tb_enemy_motion_ctrl;

  localparam int X0    = 560;
  localparam int Y0    = 400;
  localparam int FPS   = 6;
  localparam int MINP  = 2;
  localparam int XMIN  = 0;
  localparam int XMAX  = 616;
  localparam int SX    = 4;
  localparam int SY    = 24;
  localparam int YLIM  = 480;
  localparam int TICK  = 480;
  localparam int IDLEV = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       enable;
  logic       alive;
  logic       speed_up;
  logic [9:0] posX;
  logic [9:0] posY;
  logic       dir;
  logic       step_pulse;
  logic       reached_bottom;

  enemy_motion_ctrl #(
    .X_INIT          (X0),
    .Y_INIT          (Y0),
    .FRAMES_PER_STEP (FPS),
    .MIN_PERIOD      (MINP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .h_counter      (h_counter),
    .v_counter      (v_counter),
    .enable         (enable),
    .alive          (alive),
    .speed_up       (speed_up),
    .posX           (posX),
    .posY           (posY),
    .dir            (dir),
    .step_pulse     (step_pulse),
    .reached_bottom (reached_bottom)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: where the enemy is and what it is doing, in plain terms.
  int mx, my, mdir, mcnt, mper;
  bit mpend, mhalt, mbot;

  task automatic model_reset();
    mx = X0; my = Y0; mdir = 0; mcnt = 0; mper = FPS;
    mpend = 0; mhalt = 0; mbot = 0;
  endtask

  task automatic model_speed();
    mper = (mper - 1 > MINP) ? mper - 1 : MINP;
  endtask

  task automatic model_step();
    if (mpend) begin
      if (my + SY >= YLIM) begin
        my = YLIM; mbot = 1; mhalt = 1;
      end else begin
        my = my + SY; mdir = 1 - mdir; mpend = 0;
      end
    end else if (mdir == 0) begin
      if (mx + SX > XMAX) mpend = 1;
      else mx = mx + SX;
    end else begin
      if (mx < XMIN + SX) mpend = 1;
      else mx = mx - SX;
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, "_posX"}, posX, mx);
    chk({ctx, "_posY"}, posY, my);
    chk({ctx, "_dir"}, dir, mdir);
    chk({ctx, "_bottom"}, reached_bottom, mbot);
  endtask

  // One frame: inputs settle, v_counter visits the tick line, outputs checked.
  // sp: 0 no speed_up, 1 early in the frame, 2 on the same clk as the step.
  task automatic run_frame(input bit en, input bit al, input int sp);
    int  p0;
    bit  was_halt;
    bit  stepped;
    p0 = pulses;
    @(negedge clk);
    enable = en; alive = al; v_counter = 10'(IDLEV);
    if (sp == 1) speed_up = 1'b1;
    @(negedge clk); speed_up = 1'b0;
    @(negedge clk);
    @(negedge clk); v_counter = 10'(TICK);
    @(negedge clk); if (sp == 2) speed_up = 1'b1;
    @(negedge clk); speed_up = 1'b0;
    @(negedge clk); v_counter = 10'(IDLEV);
    @(negedge clk);
    @(negedge clk);

    was_halt = mhalt;
    stepped  = 0;
    if (!mhalt && sp == 1) model_speed();
    if (!mhalt && en && al) begin
      if (mcnt + 1 >= mper) begin
        mcnt = 0;
        model_step();
        stepped = 1;
      end else begin
        mcnt++;
      end
    end
    if (!was_halt && sp == 2) model_speed();

    check_outputs("frame");
    chk("frame_pulses", 32'(pulses - p0), 32'(stepped));
  endtask

  // Async reset mid-frame with v_counter parked on the tick line across release.
  task automatic reset_test(input string ctx);
    int p0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    p0 = pulses;
    model_reset();
    check_outputs({ctx, "_async"});
    chk({ctx, "_async_pulse"}, step_pulse, 0);
    @(negedge clk); v_counter = 10'(TICK); enable = 1'b1; alive = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    v_counter = 10'(IDLEV);
    @(negedge clk);
    chk({ctx, "_no_spurious"}, 32'(pulses - p0), 0);
    check_outputs({ctx, "_release"});
  endtask

  initial begin
    bit did_drop_reset;
    bit en;
    bit al;
    int r;
    int sp;

    reset = 1'b1; enable = 1'b0; alive = 1'b1; speed_up = 1'b0;
    h_counter = '0; v_counter = 10'(IDLEV);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("por");
    chk("por_pulse", step_pulse, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed opening: plain stepping, then a speed_up on the step clk.
    for (int i = 0; i < 2 * FPS; i++) run_frame(1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) run_frame(1'b1, 1'b1, (i == 0) ? 2 : 0);
    for (int i = 0; i < 5; i++) run_frame(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) run_frame(1'b1, 1'b1, 0);

    did_drop_reset = 0;
    for (int f = 0; f < 4000 && !mhalt; f++) begin
      en = ($urandom_range(0, 9) != 0);
      al = ($urandom_range(0, 7) != 0);
      r  = $urandom_range(0, 39);
      sp = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      run_frame(en, al, sp);
      if (!did_drop_reset && mpend && en && !mhalt) begin
        reset_test("drop_rst");
        did_drop_reset = 1;
      end
    end
    chk("halt_reached", mhalt, 1);
    chk("drop_reset_done", did_drop_reset, 1);

    // Terminal state: nothing moves, nothing pulses.
    for (int i = 0; i < 10; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2));
    end

    reset_test("halt_rst");
    for (int i = 0; i < 2 * FPS + 2; i++) run_frame(1'b1, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
